// File: rtl/srl_update_ctrl_if.sv
// Rule-update request channel into the SRL update controller.
// Handshake: a request transfers on a clock edge where upd_valid and upd_ready are both 1; the requester holds upd_valid and the fields stable until then, and nothing presented while upd_ready=0 is queued.
interface srl_update_ctrl_if #(
    parameter int IDX_W = 3
);
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_entry;
    logic [4:0]       upd_key;
    logic [4:0]       upd_mask;
    logic             upd_en;

    modport master (
        output upd_valid,
        output upd_entry,
        output upd_key,
        output upd_mask,
        output upd_en,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_entry,
        input  upd_key,
        input  upd_mask,
        input  upd_en,
        output upd_ready
    );
endinterface

// File: rtl/srl_update_ctrl.sv
// Expands one 5-bit key/mask rule update into a 32-entry match truth table
// and shifts it serially (address 31 first) into one SRL32 of the CAM bank.
module srl_update_ctrl #(
    parameter int NUM_SRL = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    srl_update_ctrl_if.slave   upd,
    output logic               srl_d,
    output logic [NUM_SRL-1:0] srl_ce,
    output logic               busy,
    output logic               upd_done,
    output logic               upd_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [4:0]         cnt, cnt_n;
    logic [IDX_W-1:0]   entry_q, entry_n;
    logic [4:0]         key_q, key_n;
    logic [4:0]         mask_q, mask_n;
    logic               en_q, en_n;
    logic               range_q, range_n;

    logic               ready_q, ready_n;
    logic               d_n, busy_n, done_n, err_n;
    logic [NUM_SRL-1:0] ce_n;

    function automatic logic match_bit(input logic [4:0] a, input logic [4:0] key,
                                       input logic [4:0] mask, input logic en);
        return en & (((a ^ key) & ~mask) == 5'd0);
    endfunction

    // Out-of-range entries decode to all zeros, so no SRL is ever enabled for them.
    function automatic logic [NUM_SRL-1:0] onehot(input logic [IDX_W-1:0] e);
        logic [NUM_SRL-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SRL; i++) begin
            r[i] = (32'(e) == i);
        end
        return r;
    endfunction

    function automatic logic out_of_range(input logic [IDX_W-1:0] e);
        return (32'(e) >= NUM_SRL);
    endfunction

    // cnt holds the address currently presented on srl_d while in SHIFT.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        entry_n = entry_q;
        key_n   = key_q;
        mask_n  = mask_q;
        en_n    = en_q;
        range_n = range_q;
        ready_n = 1'b0;
        d_n     = 1'b0;
        ce_n    = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (upd.upd_valid && ready_q) begin
                    state_n = SHIFT;
                    cnt_n   = 5'd31;
                    entry_n = upd.upd_entry;
                    key_n   = upd.upd_key;
                    mask_n  = upd.upd_mask;
                    en_n    = upd.upd_en;
                    range_n = out_of_range(upd.upd_entry);
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    d_n     = match_bit(5'd31, upd.upd_key, upd.upd_mask, upd.upd_en);
                    ce_n    = onehot(upd.upd_entry);
                end
            end
            SHIFT: begin
                if (cnt == 5'd0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = range_q;
                end else begin
                    cnt_n  = cnt - 5'd1;
                    busy_n = 1'b1;
                    d_n    = match_bit(cnt - 5'd1, key_q, mask_q, en_q);
                    ce_n   = onehot(entry_q);
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = 5'd31;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 5'd31;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd31;
            entry_q  <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            en_q     <= 1'b0;
            range_q  <= 1'b0;
            ready_q  <= 1'b1;
            srl_d    <= 1'b0;
            srl_ce   <= '0;
            busy     <= 1'b0;
            upd_done <= 1'b0;
            upd_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            entry_q  <= entry_n;
            key_q    <= key_n;
            mask_q   <= mask_n;
            en_q     <= en_n;
            range_q  <= range_n;
            ready_q  <= ready_n;
            srl_d    <= d_n;
            srl_ce   <= ce_n;
            busy     <= busy_n;
            upd_done <= done_n;
            upd_err  <= err_n;
        end
    end

    assign upd.upd_ready = ready_q;
    assign dbg_state     = state;

endmodule

// File: doc/srl_update_ctrl.md
Name: srl_update_ctrl

Overview:
- Update-logic stage directly upstream of the 8-way SRL32 register-file bank in the fractured CAM.
- Takes one rule-update request for a 5-bit key slice: target entry, key, don't-care mask, install/erase.
- Expands the request into the 32-bit match truth table and shifts it serially into the selected SRL over 32 cycles.
- Drives the bank's shared serial data input and its per-entry clock enables.

Parameters:
- NUM_SRL, 8: number of SRL entries driven (width of srl_ce).
- IDX_W, 3: width of the entry index; must satisfy 2**IDX_W >= NUM_SRL.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- upd_valid  input  1  update request valid.
- upd_ready  output  1  controller can accept a request.
- upd_entry  input  IDX_W  target SRL index.
- upd_key  input  5  key slice to match.
- upd_mask  input  5  don't-care mask; bit=1 means that key bit is ignored.
- upd_en  input  1  1 = install rule, 0 = erase entry (all zeros).
- srl_d  output  1  serial data to the SRL bank.
- srl_ce  output  NUM_SRL  one-hot shift enables to the SRL bank.
- busy  output  1  shift sequence in progress.
- upd_done  output  1  one-cycle pulse when a sequence completes.
- upd_err  output  1  one-cycle pulse, coincident with upd_done, when upd_entry >= NUM_SRL.

Behaviour:
- All outputs are registered.
- Reset values: srl_d=0, srl_ce=0, busy=0, upd_done=0, upd_err=0, upd_ready=1, state=IDLE, counter=31.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - upd_ready=1.
  - On upd_valid&upd_ready, latch entry, key, mask, en and a range flag (entry>=NUM_SRL); set counter=31; go to SHIFT.
- SHIFT:
  - Lasts exactly 32 cycles, named steps 0..31; the 5-bit counter a runs 31 down to 0 (step s has a=31-s).
  - srl_d = en & (((a ^ key) & ~mask) == 0).
  - srl_ce = one-hot of the latched entry, held constant for all 32 cycles.
  - srl_ce = 0 when the range flag is set; srl_d still toggles normally.
  - busy=1 and upd_ready=0 throughout.
  - After step 31 (a=0), go to DONE.
- Bit order: the first bit shifted is address 31 and the last is address 0. This leaves SRL bit n = match(n), so Q31 (SRL bit 31) carries match(31).
- Timing: request accepted at edge T; srl_ce/srl_d valid in cycles T+1..T+32.
- DONE:
  - Lasts 1 cycle (T+33): srl_ce=0, srl_d=0, busy=0, upd_done=1, upd_err=range flag, upd_ready=0.
  - Returns to IDLE; the earliest next accept is at T+34.
- Requests presented while upd_ready=0 are ignored and not queued. The requester must hold upd_valid until accepted.
- Input fields are sampled only at accept; changes during SHIFT have no effect.
- Erase (en=0): 32 zero bits are shifted into the target; mask and key are ignored.
- mask=5'b11111 with en=1: all 32 bits = 1.
- Reset mid-SHIFT:
  - Next edge forces srl_ce=0 and state to IDLE; no upd_done pulse.
  - Target SRL contents are undefined; the requester must re-issue the update.
- srl_ce is never multi-hot. srl_ce is zero outside SHIFT.

Test Plan:
- Reset, then entry=2, key=5'b10110, mask=0, en=1. Required: srl_ce=8'h04 for exactly 32 cycles; srl_d=1 only at step 9 (a=22); upd_done at T+33; a model SRL reads 1 at address 22 only.
- entry=5, key=5'b10100, mask=5'b00011, en=1. Required: srl_ce=8'h20; srl_d=1 at steps 8..11 (a=23..20), 0 elsewhere; model SRL = 32'h00F00000.
- entry=0, mask=5'b11111, en=1, then entry=0, en=0. Required: first sequence all 32 bits 1 (model 32'hFFFFFFFF); second all 0 (model 32'h0).
- NUM_SRL=6, entry=7. Required: srl_ce stays 0 for 32 cycles; upd_done=1 and upd_err=1 together at T+33.
- Hold upd_valid high continuously with changing fields during SHIFT. Required: only the first request is accepted; the next accept occurs at T+34 with the values present then; upd_ready low T+1..T+33.
- Assert rst at step 10 of a sequence. Required: srl_ce=0 next cycle, no upd_done, upd_ready=1; a fresh request then completes normally.
